// File: rtl/hall_call_registry_if.sv
// Bundle of car-position, service and button signals between the hall/cabin panels,
// the scheduler and the hall call registry.
interface hall_call_registry_if #(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = 3
);
    localparam int CNT_W = $clog2(3 * FLOORS + 1);

    logic [FLOOR_W-1:0] cur_floor;
    logic               svc_valid;
    logic               svc_up;
    logic               svc_down;
    logic [FLOORS-1:0]  upcall_in;
    logic [FLOORS-1:0]  downcall_in;
    logic [FLOORS-1:0]  cabin_in;
    logic [FLOORS-1:0]  cabin_cancel;

    logic [FLOORS-1:0]  upcall;
    logic [FLOORS-1:0]  downcall;
    logic [FLOORS-1:0]  cabin;
    logic               req_above;
    logic               req_below;
    logic               req_here;
    logic [CNT_W-1:0]   pending_count;

    // Master drives buttons and car state; the registry answers with requests.
    modport master (
        output cur_floor, svc_valid, svc_up, svc_down,
        output upcall_in, downcall_in, cabin_in, cabin_cancel,
        input  upcall, downcall, cabin,
        input  req_above, req_below, req_here, pending_count
    );

    modport slave (
        input  cur_floor, svc_valid, svc_up, svc_down,
        input  upcall_in, downcall_in, cabin_in, cabin_cancel,
        output upcall, downcall, cabin,
        output req_above, req_below, req_here, pending_count
    );
endinterface

// File: rtl/hall_call_registry.sv
// Latches hall up/down calls and cabin buttons on press edges, clears them when the
// car services a floor, and summarises outstanding requests relative to the car.
module hall_call_registry #(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    hall_call_registry_if.slave  bus
);
    localparam int CNT_W = $clog2(3 * FLOORS + 1);

    // Top floor has no up button, ground floor has no down button.
    localparam logic [FLOORS-1:0] UP_LEGAL = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0] DN_LEGAL = {{(FLOORS-1){1'b1}}, 1'b0};

    logic [FLOORS-1:0] r_up;
    logic [FLOORS-1:0] r_dn;
    logic [FLOORS-1:0] r_cab;
    logic [FLOORS-1:0] r_up_prev;
    logic [FLOORS-1:0] r_dn_prev;
    logic [FLOORS-1:0] r_cab_prev;

    logic [FLOORS-1:0] w_floor_hit;
    logic [FLOORS-1:0] w_above_mask;
    logic [FLOORS-1:0] w_below_mask;
    logic              w_in_range;
    logic              w_seen;
    logic [FLOORS-1:0] w_svc_mask;
    logic [FLOORS-1:0] w_set_up;
    logic [FLOORS-1:0] w_set_dn;
    logic [FLOORS-1:0] w_set_cab;
    logic [FLOORS-1:0] w_up_next;
    logic [FLOORS-1:0] w_dn_next;
    logic [FLOORS-1:0] w_cab_next;
    logic [FLOORS-1:0] w_any;
    logic [CNT_W-1:0]  w_count;

    // One-hot decode of cur_floor; an out-of-range floor decodes to all zeros, which
    // disables service and every summary without a separate range compare.
    always_comb begin
        w_floor_hit  = '0;
        w_above_mask = '0;
        w_below_mask = '0;
        w_seen       = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            w_floor_hit[i] = (bus.cur_floor == FLOOR_W'(i));
        end
        w_in_range = |w_floor_hit;
        for (int i = 0; i < FLOORS; i++) begin
            w_above_mask[i] = w_seen;
            w_seen          = w_seen | w_floor_hit[i];
            w_below_mask[i] = w_in_range & ~w_seen;
        end
    end

    assign w_svc_mask = bus.svc_valid ? w_floor_hit : '0;

    assign w_set_up  = bus.upcall_in   & ~r_up_prev  & UP_LEGAL;
    assign w_set_dn  = bus.downcall_in & ~r_dn_prev  & DN_LEGAL;
    assign w_set_cab = bus.cabin_in    & ~r_cab_prev;

    // Clears are applied after the set so a same-cycle press loses to service/cancel.
    assign w_up_next  = (r_up  | w_set_up)  & ~(w_svc_mask & {FLOORS{bus.svc_up}});
    assign w_dn_next  = (r_dn  | w_set_dn)  & ~(w_svc_mask & {FLOORS{bus.svc_down}});
    assign w_cab_next = (r_cab | w_set_cab) & ~w_svc_mask & ~bus.cabin_cancel;

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_up       <= '0;
            r_dn       <= '0;
            r_cab      <= '0;
            r_up_prev  <= '1;
            r_dn_prev  <= '1;
            r_cab_prev <= '1;
        end else begin
            r_up       <= w_up_next;
            r_dn       <= w_dn_next;
            r_cab      <= w_cab_next;
            r_up_prev  <= bus.upcall_in;
            r_dn_prev  <= bus.downcall_in;
            r_cab_prev <= bus.cabin_in;
        end
    end

    assign w_any = r_up | r_dn | r_cab;

    always_comb begin
        w_count = '0;
        for (int i = 0; i < FLOORS; i++) begin
            w_count = w_count + CNT_W'(r_up[i]) + CNT_W'(r_dn[i]) + CNT_W'(r_cab[i]);
        end
    end

    assign bus.upcall        = r_up;
    assign bus.downcall      = r_dn;
    assign bus.cabin         = r_cab;
    assign bus.req_above     = |(w_any & w_above_mask);
    assign bus.req_below     = |(w_any & w_below_mask);
    assign bus.req_here      = |(w_any & w_floor_hit);
    assign bus.pending_count = w_count;
endmodule

// File: tb/tb_hall_call_registry.sv
// Directed bench for hall_call_registry: an 8-floor and a 12-floor instance driven
// through press edges, service clears, cancels, resets and out-of-range floors.
module tb_hall_call_registry;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hall_call_registry_if #(.FLOORS(8),  .FLOOR_W(3)) ifa ();
    hall_call_registry_if #(.FLOORS(12), .FLOOR_W(4)) ifb ();

    hall_call_registry #(.FLOORS(8),  .FLOOR_W(3)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    hall_call_registry #(.FLOORS(12), .FLOOR_W(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked there too.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        ifa.cur_floor = '0; ifa.svc_valid = 0; ifa.svc_up = 0; ifa.svc_down = 0;
        ifa.upcall_in = '0; ifa.downcall_in = '0; ifa.cabin_in = 8'h04; ifa.cabin_cancel = '0;
        ifb.cur_floor = '0; ifb.svc_valid = 0; ifb.svc_up = 0; ifb.svc_down = 0;
        ifb.upcall_in = '0; ifb.downcall_in = '0; ifb.cabin_in = '0; ifb.cabin_cancel = '0;
        tick(2);
        check("rst_upcall",   ifa.upcall, 0);
        check("rst_downcall", ifa.downcall, 0);
        check("rst_cabin",    ifa.cabin, 0);
        check("rst_above",    ifa.req_above, 0);
        check("rst_here",     ifa.req_here, 0);
        check("rst_count",    ifa.pending_count, 0);

        // Button held through reset must not latch.
        rst = 1'b0;
        tick(5);
        check("held_thru_rst", ifa.cabin, 0);
        ifa.cabin_in = '0;
        tick();
        check("released", ifa.cabin, 0);
        ifa.cabin_in = 8'h04;
        tick();
        check("repress_cabin", ifa.cabin, 8'h04);
        check("repress_count", ifa.pending_count, 1);
        check("repress_above", ifa.req_above, 1);
        ifa.cabin_in = '0;
        ifa.cur_floor = 3'd2; ifa.svc_valid = 1;
        tick();
        check("svc_no_dir_cabin", ifa.cabin, 0);
        ifa.svc_valid = 0;

        // Illegal hall buttons are masked.
        ifa.upcall_in = 8'h84; ifa.downcall_in = 8'h01;
        tick();
        check("illegal_up",    ifa.upcall, 8'h04);
        check("illegal_dn",    ifa.downcall, 0);
        check("illegal_count", ifa.pending_count, 1);
        ifa.upcall_in = '0; ifa.downcall_in = '0;
        ifa.svc_valid = 1; ifa.svc_up = 1;
        tick();
        check("clear_up2", ifa.upcall, 0);
        ifa.svc_valid = 0; ifa.svc_up = 0;

        // Direction-aware service at floor 3.
        ifa.upcall_in = 8'h08; ifa.downcall_in = 8'h08; ifa.cabin_in = 8'h08;
        tick();
        check("three_count", ifa.pending_count, 3);
        ifa.upcall_in = '0; ifa.downcall_in = '0; ifa.cabin_in = '0;
        ifa.cur_floor = 3'd3; ifa.svc_valid = 1; ifa.svc_up = 1; ifa.svc_down = 0;
        tick();
        ifa.svc_valid = 0; ifa.svc_up = 0;
        check("svc3_up",    ifa.upcall, 0);
        check("svc3_cabin", ifa.cabin, 0);
        check("svc3_dn",    ifa.downcall, 8'h08);
        check("svc3_here",  ifa.req_here, 1);
        check("svc3_above", ifa.req_above, 0);
        check("svc3_below", ifa.req_below, 0);
        check("svc3_count", ifa.pending_count, 1);
        ifa.svc_valid = 1; ifa.svc_down = 1;
        tick();
        check("svc3_dn_clear", ifa.downcall, 0);
        ifa.svc_valid = 0; ifa.svc_down = 0;

        // Multi-cycle service at floor 5 blocks a held up-press there.
        ifa.cur_floor = 3'd5; ifa.svc_valid = 1; ifa.svc_up = 1;
        tick();
        ifa.upcall_in = 8'h20; ifa.cabin_in = 8'h40;
        tick();
        check("hold_svc_c2", ifa.upcall, 0);
        check("other_floor", ifa.cabin, 8'h40);
        tick(2);
        check("hold_svc_c4", ifa.upcall, 0);
        ifa.svc_valid = 0; ifa.svc_up = 0; ifa.cabin_in = '0;
        tick(2);
        check("held_after_svc", ifa.upcall, 0);
        check("above_count",    ifa.pending_count, 1);
        check("below_none",     ifa.req_below, 0);
        ifa.upcall_in = '0;
        tick();
        ifa.upcall_in = 8'h20;
        tick();
        check("repress_up5", ifa.upcall, 8'h20);
        check("here5",       ifa.req_here, 1);
        ifa.upcall_in = '0;
        ifa.cabin_cancel = 8'h40; ifa.svc_valid = 1; ifa.svc_up = 1;
        tick();
        check("cancel6",  ifa.cabin, 0);
        check("clear_up5", ifa.upcall, 0);
        ifa.cabin_cancel = '0; ifa.svc_valid = 0; ifa.svc_up = 0;

        // Cancel vs. press.
        ifa.cabin_in = 8'h10;
        tick();
        ifa.cabin_in = '0;
        check("cab4", ifa.cabin, 8'h10);
        ifa.cabin_cancel = 8'h10; ifa.cabin_in = 8'h02;
        tick();
        check("cancel_plus_press", ifa.cabin, 8'h02);
        ifa.cabin_cancel = '0; ifa.cabin_in = '0;
        tick();
        ifa.cabin_cancel = 8'h10; ifa.cabin_in = 8'h10;
        tick();
        check("cancel_beats_press", ifa.cabin, 8'h02);
        ifa.cabin_cancel = '0;
        tick();
        check("no_relatch", ifa.cabin, 8'h02);
        check("below5",     ifa.req_below, 1);
        ifa.cabin_in = '0;

        // Reset mid-operation.
        ifa.upcall_in = 8'h01;
        tick();
        check("pre_rst_up", ifa.upcall, 8'h01);
        rst = 1'b1;
        tick();
        check("mid_rst_up",    ifa.upcall, 0);
        check("mid_rst_cabin", ifa.cabin, 0);
        check("mid_rst_count", ifa.pending_count, 0);
        rst = 1'b0;
        tick(2);
        check("post_rst_held", ifa.upcall, 0);
        ifa.upcall_in = '0;

        // 12-floor instance: summaries and out-of-range floor.
        ifb.cabin_in = 12'h800; ifb.upcall_in = 12'h001;
        tick();
        ifb.cabin_in = '0; ifb.upcall_in = '0;
        ifb.cur_floor = 4'd6;
        #1;
        check("b_above", ifb.req_above, 1);
        check("b_below", ifb.req_below, 1);
        check("b_here",  ifb.req_here, 0);
        check("b_count", ifb.pending_count, 2);
        ifb.cur_floor = 4'd13;
        #1;
        check("b_oor_above", ifb.req_above, 0);
        check("b_oor_below", ifb.req_below, 0);
        check("b_oor_here",  ifb.req_here, 0);
        ifb.svc_valid = 1; ifb.svc_up = 1; ifb.svc_down = 1;
        tick();
        check("b_oor_cabin", ifb.cabin, 12'h800);
        check("b_oor_up",    ifb.upcall, 12'h001);
        ifb.svc_valid = 0; ifb.svc_up = 0; ifb.svc_down = 0;
        ifb.cur_floor = 4'd11;
        #1;
        check("b_top_here",  ifb.req_here, 1);
        check("b_top_above", ifb.req_above, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
